// File: rtl/all4_gray.sv
// all4_gray: two-stage RGB to grayscale luminance pipeline.
//   Y = (77*R + 150*G + 29*B + 128) >> 8, with round-half-up.
//   The coefficients sum to 256, so the result never exceeds 255.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears every pipeline register
//   in_valid   r/g/b carry a pixel this cycle
//   r, g, b    32-bit samples; only bits [7:0] are used
//   out        luminance, zero-extended 8-bit result
//   vr/vg/vb   weighted colour terms for the same pixel, zero-extended 16-bit
//   out_valid  out/vr/vg/vb belong to the pixel presented two cycles earlier
//
// The output registers hold the last valid result. They load only when a
// valid pixel leaves stage 1, so out_valid=0 cycles keep the previous pixel
// visible.
module all4_gray (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] r,
    input  logic [31:0] g,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic [31:0] vr,
    output logic [31:0] vg,
    output logic [31:0] vb,
    output logic        out_valid
);

    localparam logic [15:0] CR = 16'd77;
    localparam logic [15:0] CG = 16'd150;
    localparam logic [15:0] CB = 16'd29;

    logic [15:0] vr_p1, vg_p1, vb_p1;
    logic        vld_p1;
    logic [7:0]  out_p2;
    logic [15:0] vr_p2, vg_p2, vb_p2;
    logic        vld_p2;

    // The upper 24 bits of each sample are ignored by definition.
    logic unused_hi;
    assign unused_hi = ^{r[31:8], g[31:8], b[31:8]};

    // Sum of the three Q0.8 terms, rounded half-up and shifted back to 8 bits.
    // The largest possible sum is 65408, so the shifted value fits in 8 bits.
    function automatic logic [7:0] round_q8(input logic [15:0] ta,
                                            input logic [15:0] tb,
                                            input logic [15:0] tc);
        logic [16:0] sum;
        sum = 17'(ta) + 17'(tb) + 17'(tc) + 17'd128;
        return 8'(sum >> 8);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vr_p1  <= '0;
            vg_p1  <= '0;
            vb_p1  <= '0;
            vld_p1 <= 1'b0;
            out_p2 <= '0;
            vr_p2  <= '0;
            vg_p2  <= '0;
            vb_p2  <= '0;
            vld_p2 <= 1'b0;
        end else begin
            // stage 1: per-channel weighting; advances every cycle
            vr_p1  <= 16'(r[7:0]) * CR;
            vg_p1  <= 16'(g[7:0]) * CG;
            vb_p1  <= 16'(b[7:0]) * CB;
            vld_p1 <= in_valid;

            // stage 2: rounded sum; data loads only for a valid pixel
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_p2 <= round_q8(vr_p1, vg_p1, vb_p1);
                vr_p2  <= vr_p1;
                vg_p2  <= vg_p1;
                vb_p2  <= vb_p1;
            end
        end
    end

    assign out       = {24'd0, out_p2};
    assign vr        = {16'd0, vr_p2};
    assign vg        = {16'd0, vg_p2};
    assign vb        = {16'd0, vb_p2};
    assign out_valid = vld_p2;

endmodule

// File: tb/tb_all4_gray.sv
// Testbench for all4_gray: fixed vector table, hand-written reset/gap
// sequences, and a random stream, all checked through a scoreboard queue.
module tb_all4_gray;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] r, g, b;
    logic [31:0] out, vr, vg, vb;
    logic        out_valid;

    all4_gray dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .r        (r),
        .g        (g),
        .b        (b),
        .out      (out),
        .vr       (vr),
        .vg       (vg),
        .vb       (vb),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] out;
        logic [31:0] vr;
        logic [31:0] vg;
        logic [31:0] vb;
    } exp_t;

    typedef struct {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
        logic [31:0] out;
        logic [31:0] vr;
        logic [31:0] vg;
        logic [31:0] vb;
    } vec_t;

    exp_t q[$];
    exp_t last;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[6];

    function automatic exp_t model(input logic [31:0] pr, input logic [31:0] pg,
                                   input logic [31:0] pb);
        exp_t e;
        int   wr, wg, wb;
        wr = int'(pr & 32'hFF) * 77;
        wg = int'(pg & 32'hFF) * 150;
        wb = int'(pb & 32'hFF) * 29;
        e.v   = 1'b1;
        e.vr  = 32'(wr);
        e.vg  = 32'(wg);
        e.vb  = 32'(wb);
        e.out = 32'((wr + wg + wb + 128) / 256);
        return e;
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e.v = 1'b0; e.out = '0; e.vr = '0; e.vg = '0; e.vb = '0;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    task automatic chk_zero(input string nm);
        cmp({nm, " out"}, out, 32'd0);
        cmp({nm, " vr"}, vr, 32'd0);
        cmp({nm, " vg"}, vg, 32'd0);
        cmp({nm, " vb"}, vb, 32'd0);
        cmp({nm, " out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Compare the DUT against the entry that entered the pipeline two steps ago.
    task automatic check_out();
        exp_t e;
        if (q.size() >= 2) begin
            e = q.pop_front();
            if (e.v) last = e;
            cmp("out_valid", {31'd0, out_valid}, {31'd0, e.v});
            cmp("out", out, last.out);
            cmp("vr", vr, last.vr);
            cmp("vg", vg, last.vg);
            cmp("vb", vb, last.vb);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pr, input logic [31:0] pg,
                         input logic [31:0] pb, input exp_t e);
        exp_t x;
        in_valid = v;
        r = pr; g = pg; b = pb;
        x = v ? e : blank();
        q.push_back(x);
    endtask

    task automatic step(input logic v, input logic [31:0] pr, input logic [31:0] pg,
                        input logic [31:0] pb);
        @(posedge clk);
        #1;
        check_out();
        drive(v, pr, pg, pb, model(pr, pg, pb));
    endtask

    // After reset the pipeline holds one empty stage-1 slot ahead of the
    // next pixel driven.
    task automatic flush();
        q.delete();
        last = blank();
        q.push_back(blank());
    endtask

    initial begin
        tbl[0] = '{32'd0,         32'd0,         32'd0,         32'd0,   32'd0,     32'd0,     32'd0};
        tbl[1] = '{32'd255,       32'd255,       32'd255,       32'd255, 32'd19635, 32'd38250, 32'd7395};
        tbl[2] = '{32'd255,       32'd0,         32'd0,         32'd77,  32'd19635, 32'd0,     32'd0};
        tbl[3] = '{32'd0,         32'd255,       32'd0,         32'd149, 32'd0,     32'd38250, 32'd0};
        tbl[4] = '{32'd0,         32'd0,         32'd255,       32'd29,  32'd0,     32'd0,     32'd7395};
        tbl[5] = '{32'h1234_5680, 32'hFF00_0064, 32'h0000_00C8, 32'd120, 32'd9856,  32'd15000, 32'd5800};

        // Reset with a pixel on the inputs; it must never emerge.
        rst = 1'b1;
        in_valid = 1'b1;
        r = 32'd255; g = 32'd255; b = 32'd255;
        @(posedge clk);
        #1;
        chk_zero("reset");
        @(posedge clk);
        #1;
        chk_zero("reset hold");
        rst = 1'b0;
        flush();
        drive(1'b0, 32'd0, 32'd0, 32'd0, blank());
        step(1'b0, 32'd0, 32'd0, 32'd0);

        // Vector table, back to back, then each vector held for three cycles.
        foreach (tbl[i]) begin
            exp_t e;
            @(posedge clk);
            #1;
            check_out();
            e = '{1'b1, tbl[i].out, tbl[i].vr, tbl[i].vg, tbl[i].vb};
            drive(1'b1, tbl[i].r, tbl[i].g, tbl[i].b, e);
        end
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) begin
                exp_t e;
                @(posedge clk);
                #1;
                check_out();
                e = '{1'b1, tbl[i].out, tbl[i].vr, tbl[i].vg, tbl[i].vb};
                drive(1'b1, tbl[i].r, tbl[i].g, tbl[i].b, e);
            end
        end

        // Gaps: outputs must hold the last valid pixel while out_valid=0.
        step(1'b1, 32'd10, 32'd20, 32'd30);
        step(1'b0, 32'd200, 32'd200, 32'd200);
        step(1'b0, 32'd99, 32'd1, 32'd7);
        step(1'b1, 32'd128, 32'd64, 32'd32);
        step(1'b0, 32'd255, 32'd0, 32'd255);
        step(1'b1, 32'd1, 32'd2, 32'd3);
        step(1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0);

        // Asynchronous reset between edges with two pixels in flight.
        step(1'b1, 32'd200, 32'd100, 32'd50);
        step(1'b1, 32'd60, 32'd70, 32'd80);
        step(1'b1, 32'd90, 32'd110, 32'd130);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #1;
        chk_zero("async reset hold");
        rst = 1'b0;
        flush();
        drive(1'b0, 32'd0, 32'd0, 32'd0, blank());
        step(1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b1, 32'd33, 32'd66, 32'd99);
        step(1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0);

        // Random stream: continuous valid first, then sparse valid.
        for (int i = 0; i < 1500; i++)
            step(1'b1, $urandom, $urandom, $urandom);
        for (int i = 0; i < 1000; i++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);

        // Drain the pipeline.
        step(1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
